// File: rtl/rename_regfile_ckpt.sv
// Architectural register file with rename (busy / ROB-tag) tracking and NCKPT branch checkpoints.
// Optional commit-to-read bypass: define RF_COMMIT_BYPASS_EN.
module rename_regfile_ckpt #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int ROB_ADDR = 4,
  parameter int NREAD    = 4,
  parameter int NCKPT    = 4,
  localparam int RW      = $clog2(NREG),
  localparam int CW      = $clog2(NCKPT)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic [NREAD*RW-1:0]       rd_id,
  output logic [NREAD*XLEN-1:0]     rd_val,
  output logic [NREAD-1:0]          rd_has_rely,
  output logic [NREAD*ROB_ADDR-1:0] rd_rely,
  input  logic                      issue_valid,
  input  logic [RW-1:0]             issue_rd,
  input  logic [ROB_ADDR-1:0]       issue_robid,
  input  logic                      commit_valid,
  input  logic [RW-1:0]             commit_rd,
  input  logic [XLEN-1:0]           commit_val,
  input  logic [ROB_ADDR-1:0]       commit_robid,
  input  logic                      ckpt_save,
  input  logic [CW-1:0]             ckpt_id,
  input  logic                      ckpt_restore,
  input  logic [CW-1:0]             restore_id,
  input  logic                      rf_clear
);

  logic [XLEN-1:0]     data_q [NREG];
  logic [NREG-1:0]     busy_q;
  logic [ROB_ADDR-1:0] rely_q [NREG];
  logic [NREG-1:0]     ckb_q  [NCKPT];
  logic [ROB_ADDR-1:0] ckr_q  [NCKPT][NREG];

  logic [NREG-1:0]     busy_d;
  logic [ROB_ADDR-1:0] rely_d [NREG];

  logic issue_hit;
  logic commit_hit;

  assign issue_hit  = issue_valid  && (issue_rd  != '0);
  assign commit_hit = commit_valid && (commit_rd != '0);

  // Next live rename map: clear > restore (+commit retire) > commit retire then issue.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    busy_d = busy_q;
    for (int r = 0; r < NREG; r++) rely_d[r] = rely_q[r];

    if (rf_clear) begin
      busy_d = '0;
      for (int r = 0; r < NREG; r++) rely_d[r] = '0;
    end else if (ckpt_restore) begin
      busy_d = ckb_q[restore_id];
      for (int r = 0; r < NREG; r++) rely_d[r] = ckr_q[restore_id][r];
      if (commit_hit && ckr_q[restore_id][commit_rd] == commit_robid) begin
        busy_d[commit_rd] = 1'b0;
        rely_d[commit_rd] = '0;
      end
    end else begin
      if (commit_hit && rely_q[commit_rd] == commit_robid) begin
        busy_d[commit_rd] = 1'b0;
        rely_d[commit_rd] = '0;
      end
      // Applied after the retire so a same-cycle issue to the same register wins.
      if (issue_hit) begin
        busy_d[issue_rd] = 1'b1;
        rely_d[issue_rd] = issue_robid;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      // NOTE: the storage arrays are reset too, checkpoint slots included, so a restore
      // right after reset can never load stale tags; this keeps them in flops, not RAM.
      busy_q <= '0;
      for (int r = 0; r < NREG; r++) begin
        data_q[r] <= '0;
        rely_q[r] <= '0;
      end
      for (int s = 0; s < NCKPT; s++) begin
        ckb_q[s] <= '0;
        for (int r = 0; r < NREG; r++) ckr_q[s][r] <= '0;
      end
    end else if (rdy_in) begin
      // NOTE: sequential state uses non-blocking assignments; where two land on the same
      // slot entry in one edge (scrub, then save), the later one takes effect.
      busy_q <= busy_d;
      for (int r = 0; r < NREG; r++) rely_q[r] <= rely_d[r];

      if (!rf_clear && commit_hit) data_q[commit_rd] <= commit_val;

      if (rf_clear) begin
        for (int s = 0; s < NCKPT; s++) begin
          ckb_q[s] <= '0;
          for (int r = 0; r < NREG; r++) ckr_q[s][r] <= '0;
        end
      end else if (!ckpt_restore) begin
        // Scrub the retiring producer from every slot so a later restore cannot revive it.
        for (int s = 0; s < NCKPT; s++) begin
          if (commit_hit && ckr_q[s][commit_rd] == commit_robid) begin
            ckb_q[s][commit_rd] <= 1'b0;
            ckr_q[s][commit_rd] <= '0;
          end
        end
        if (ckpt_save) begin
          ckb_q[ckpt_id] <= busy_d;
          for (int r = 0; r < NREG; r++) ckr_q[ckpt_id][r] <= rely_d[r];
        end
      end
    end
  end

  // Combinational operand lookup per read port.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [RW-1:0]       id;
    logic [XLEN-1:0]     val;
    logic                has;
    logic [ROB_ADDR-1:0] rel;

    assign id = rd_id[k*RW +: RW];

    always_comb begin
      val = '0;
      has = 1'b0;
      rel = '0;
      if (id != '0) begin
        val = data_q[id];
        has = busy_q[id];
        rel = rely_q[id];
        if (issue_hit && issue_rd == id) begin
          has = 1'b1;
          rel = issue_robid;
        end
`ifdef RF_COMMIT_BYPASS_EN
        else if (commit_hit && commit_rd == id && rely_q[id] == commit_robid) begin
          val = commit_val;
          has = 1'b0;
        end
`endif
      end
    end

    assign rd_val[k*XLEN +: XLEN]         = val;
    assign rd_has_rely[k]                 = has;
    assign rd_rely[k*ROB_ADDR +: ROB_ADDR] = rel;
  end

endmodule

// File: tb/tb_rename_regfile_ckpt.sv
// Self-checking bench for rename_regfile_ckpt: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_rename_regfile_ckpt;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RA   = 4;
  localparam int NR   = 4;
  localparam int NC   = 4;
  localparam int RW   = 5;
  localparam int CW   = 2;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic               rst_in;
  logic               rdy_in;
  logic [NR*RW-1:0]   rd_id;
  logic [NR*XLEN-1:0] rd_val;
  logic [NR-1:0]      rd_has_rely;
  logic [NR*RA-1:0]   rd_rely;
  logic               issue_valid;
  logic [RW-1:0]      issue_rd;
  logic [RA-1:0]      issue_robid;
  logic               commit_valid;
  logic [RW-1:0]      commit_rd;
  logic [XLEN-1:0]    commit_val;
  logic [RA-1:0]      commit_robid;
  logic               ckpt_save;
  logic [CW-1:0]      ckpt_id;
  logic               ckpt_restore;
  logic [CW-1:0]      restore_id;
  logic               rf_clear;

  rename_regfile_ckpt #(
    .XLEN(XLEN), .NREG(NREG), .ROB_ADDR(RA), .NREAD(NR), .NCKPT(NC)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rd_id(rd_id), .rd_val(rd_val), .rd_has_rely(rd_has_rely), .rd_rely(rd_rely),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_robid(issue_robid),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_robid(commit_robid),
    .ckpt_save(ckpt_save), .ckpt_id(ckpt_id),
    .ckpt_restore(ckpt_restore), .restore_id(restore_id),
    .rf_clear(rf_clear)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-register records and whole-map snapshots.
  logic [XLEN-1:0] m_data [NREG];
  bit              m_busy [NREG];
  logic [RA-1:0]   m_rely [NREG];
  bit              m_cb   [NC][NREG];
  logic [RA-1:0]   m_cr   [NC][NREG];

  always @(posedge clk_in) begin
    if (rst_in) begin
      for (int r = 0; r < NREG; r++) begin
        m_data[r] = '0; m_busy[r] = 0; m_rely[r] = '0;
        for (int s = 0; s < NC; s++) begin m_cb[s][r] = 0; m_cr[s][r] = '0; end
      end
    end else if (rdy_in) begin
      if (rf_clear) begin
        for (int r = 0; r < NREG; r++) begin
          m_busy[r] = 0; m_rely[r] = '0;
          for (int s = 0; s < NC; s++) begin m_cb[s][r] = 0; m_cr[s][r] = '0; end
        end
      end else if (ckpt_restore) begin
        for (int r = 0; r < NREG; r++) begin
          m_busy[r] = m_cb[restore_id][r];
          m_rely[r] = m_cr[restore_id][r];
        end
        if (commit_valid && commit_rd != 0) begin
          m_data[commit_rd] = commit_val;
          if (m_rely[commit_rd] == commit_robid) begin
            m_busy[commit_rd] = 0; m_rely[commit_rd] = '0;
          end
        end
      end else begin
        if (commit_valid && commit_rd != 0) begin
          m_data[commit_rd] = commit_val;
          if (m_rely[commit_rd] == commit_robid) begin
            m_busy[commit_rd] = 0; m_rely[commit_rd] = '0;
          end
          for (int s = 0; s < NC; s++)
            if (m_cr[s][commit_rd] == commit_robid) begin
              m_cb[s][commit_rd] = 0; m_cr[s][commit_rd] = '0;
            end
        end
        if (issue_valid && issue_rd != 0) begin
          m_busy[issue_rd] = 1; m_rely[issue_rd] = issue_robid;
        end
        if (ckpt_save)
          for (int r = 0; r < NREG; r++) begin
            m_cb[ckpt_id][r] = m_busy[r];
            m_cr[ckpt_id][r] = m_rely[r];
          end
      end
    end
  end

  // Compare process: all read ports against the model, every cycle.
  always @(negedge clk_in) begin
    if (chk_en) begin
      for (int k = 0; k < NR; k++) begin
        logic [RW-1:0]   id;
        logic [XLEN-1:0] ev;
        logic            eh;
        logic [RA-1:0]   er;
        id = rd_id[k*RW +: RW];
        ev = '0; eh = 1'b0; er = '0;
        if (id != 0) begin
          ev = m_data[id]; eh = m_busy[id]; er = m_rely[id];
          if (issue_valid && issue_rd == id) begin
            eh = 1'b1; er = issue_robid;
          end
`ifdef RF_COMMIT_BYPASS_EN
          else if (commit_valid && commit_rd == id && m_rely[id] == commit_robid) begin
            ev = commit_val; eh = 1'b0;
          end
`endif
        end
        check($sformatf("model p%0d val", k), 64'(rd_val[k*XLEN +: XLEN]), 64'(ev));
        check($sformatf("model p%0d has", k), 64'(rd_has_rely[k]), 64'(eh));
        check($sformatf("model p%0d rely", k), 64'(rd_rely[k*RA +: RA]), 64'(er));
      end
    end
  end

  function automatic logic [XLEN-1:0] val_of(input int k);
    return rd_val[k*XLEN +: XLEN];
  endfunction
  function automatic logic [RA-1:0] rely_of(input int k);
    return rd_rely[k*RA +: RA];
  endfunction

  task automatic idle();
    rdy_in = 1'b1; rf_clear = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; issue_robid = '0;
    commit_valid = 1'b0; commit_rd = '0; commit_val = '0; commit_robid = '0;
    ckpt_save = 1'b0; ckpt_id = '0; ckpt_restore = 1'b0; restore_id = '0;
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
    idle();
  endtask

  task automatic set_rd(input logic [RW-1:0] a, b, c, d);
    rd_id = {d, c, b, a};
  endtask

  initial begin
    rst_in = 1'b1;
    idle();
    set_rd(5, 5, 5, 5);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    chk_en = 1'b1;

    // Reset state on all ports.
    @(negedge clk_in);
    for (int k = 0; k < NR; k++) begin
      check($sformatf("reset p%0d val", k), 64'(val_of(k)), 64'd0);
      check($sformatf("reset p%0d has", k), 64'(rd_has_rely[k]), 64'd0);
      check($sformatf("reset p%0d rely", k), 64'(rely_of(k)), 64'd0);
    end
    @(posedge clk_in); #1;

    // Same-cycle issue bypass, then from the map.
    issue_valid = 1; issue_rd = 5; issue_robid = 3; set_rd(5, 0, 5, 5);
    @(negedge clk_in);
    check("bypass has", 64'(rd_has_rely[0]), 64'd1);
    check("bypass rely", 64'(rely_of(0)), 64'd3);
    check("x0 has", 64'(rd_has_rely[1]), 64'd0);
    tick();
    @(negedge clk_in);
    check("map has x5", 64'(rd_has_rely[0]), 64'd1);
    check("map rely x5", 64'(rely_of(0)), 64'd3);
    @(posedge clk_in); #1;

    // Commit with same-cycle issue to the same register; then stale-tag commit.
    commit_valid = 1; commit_rd = 5; commit_val = 32'hDEAD; commit_robid = 3;
    issue_valid = 1; issue_rd = 5; issue_robid = 7;
    tick();
    @(negedge clk_in);
    check("issue wins val", 64'(val_of(0)), 64'hDEAD);
    check("issue wins has", 64'(rd_has_rely[0]), 64'd1);
    check("issue wins rely", 64'(rely_of(0)), 64'd7);
    @(posedge clk_in); #1;
    commit_valid = 1; commit_rd = 5; commit_val = 32'hBEEF; commit_robid = 2;
    tick();
    @(negedge clk_in);
    check("stale commit val", 64'(val_of(0)), 64'hBEEF);
    check("stale commit has", 64'(rd_has_rely[0]), 64'd1);
    check("stale commit rely", 64'(rely_of(0)), 64'd7);
    @(posedge clk_in); #1;

    // Save / restore of the rename map.
    issue_valid = 1; issue_rd = 1; issue_robid = 1; tick();
    ckpt_save = 1; ckpt_id = 2; tick();
    issue_valid = 1; issue_rd = 1; issue_robid = 4; tick();
    issue_valid = 1; issue_rd = 2; issue_robid = 5; tick();
    ckpt_restore = 1; restore_id = 2; tick();
    set_rd(1, 2, 5, 0);
    @(negedge clk_in);
    check("restore x1 has", 64'(rd_has_rely[0]), 64'd1);
    check("restore x1 rely", 64'(rely_of(0)), 64'd1);
    check("restore x2 has", 64'(rd_has_rely[1]), 64'd0);
    check("restore x5 rely", 64'(rely_of(2)), 64'd7);
    @(posedge clk_in); #1;

    // Commit scrubs a checkpoint before it is restored.
    issue_valid = 1; issue_rd = 3; issue_robid = 6; ckpt_save = 1; ckpt_id = 0; tick();
    commit_valid = 1; commit_rd = 3; commit_val = 32'h1234; commit_robid = 6; tick();
    ckpt_restore = 1; restore_id = 0; tick();
    set_rd(3, 1, 0, 0);
    @(negedge clk_in);
    check("scrub x3 has", 64'(rd_has_rely[0]), 64'd0);
    check("scrub x3 val", 64'(val_of(0)), 64'h1234);
    check("scrub x1 has", 64'(rd_has_rely[1]), 64'd1);
    @(posedge clk_in); #1;

    // rdy_in low freezes state.
    rdy_in = 0; issue_valid = 1; issue_rd = 4; issue_robid = 9;
    commit_valid = 1; commit_rd = 5; commit_val = 32'h55; commit_robid = 7;
    tick();
    set_rd(4, 5, 0, 0);
    @(negedge clk_in);
    check("hold x4 has", 64'(rd_has_rely[0]), 64'd0);
    check("hold x5 val", 64'(val_of(1)), 64'hBEEF);
    check("hold x5 has", 64'(rd_has_rely[1]), 64'd1);
    @(posedge clk_in); #1;

    // Full flush, then restore shows nothing busy.
    rf_clear = 1; issue_valid = 1; issue_rd = 6; issue_robid = 2; tick();
    set_rd(1, 5, 6, 3);
    @(negedge clk_in);
    check("clear x1 has", 64'(rd_has_rely[0]), 64'd0);
    check("clear x5 has", 64'(rd_has_rely[1]), 64'd0);
    check("clear x6 has", 64'(rd_has_rely[2]), 64'd0);
    check("clear x5 val", 64'(val_of(1)), 64'hBEEF);
    @(posedge clk_in); #1;
    ckpt_restore = 1; restore_id = 2; tick();
    @(negedge clk_in);
    check("post-clear x1 has", 64'(rd_has_rely[0]), 64'd0);
    check("post-clear x5 has", 64'(rd_has_rely[1]), 64'd0);
    @(posedge clk_in); #1;

    // Randomized traffic on a small register window to force collisions.
    for (int i = 0; i < 3000; i++) begin
      rdy_in       = ($urandom_range(9) != 0);
      rd_id        = {RW'($urandom_range(7)), RW'($urandom_range(7)),
                      RW'($urandom_range(7)), RW'($urandom_range(31))};
      issue_valid  = $urandom_range(1);
      issue_rd     = RW'($urandom_range(7));
      issue_robid  = RA'($urandom);
      commit_valid = $urandom_range(1);
      commit_rd    = RW'($urandom_range(7));
      commit_val   = $urandom;
      commit_robid = ($urandom_range(2) != 0) ? m_rely[commit_rd] : RA'($urandom);
      ckpt_save    = ($urandom_range(3) == 0);
      ckpt_id      = CW'($urandom);
      ckpt_restore = ($urandom_range(11) == 0);
      restore_id   = CW'($urandom);
      rf_clear     = ($urandom_range(49) == 0);
      @(posedge clk_in); #1;
    end

    idle();
    @(negedge clk_in);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rename_regfile_ckpt.md
Name: rename_regfile_ckpt

Overview:
- Parametrised architectural register file with rename (busy/ROB-tag) tracking for the out-of-order RISC-V core.
- Serves NREAD combinational operand lookups to RS/LSB, records a new producer tag per issued instruction, and writes values on ROB commit.
- Adds NCKPT branch checkpoints of the busy/tag map, so a mispredict restores the map at the branch instead of a full flush.

Parameters:
- XLEN, 32, data width.
- NREG, 32, architectural register count; index width RW = clog2(NREG); register 0 is hardwired zero.
- ROB_ADDR, 4, ROB tag width.
- NREAD, 4, number of read ports; all read buses are flattened with port k in bits [k*W +: W].
- NCKPT, 4, number of checkpoint slots; slot index width CW = clog2(NCKPT).

Ports:
- clk_in  in  1  clock; single clock domain.
- rst_in  in  1  reset, synchronous, active-high.
- rdy_in  in  1  global enable; when low, no state changes.
- rd_id  in  NREAD*RW  read register indices.
- rd_val  out  NREAD*XLEN  committed values.
- rd_has_rely  out  NREAD  operand pending.
- rd_rely  out  NREAD*ROB_ADDR  producer ROB tag.
- issue_valid  in  1  rename a destination this cycle.
- issue_rd  in  RW  destination register.
- issue_robid  in  ROB_ADDR  producer tag.
- commit_valid  in  1  ROB commit this cycle.
- commit_rd  in  RW  committed destination register.
- commit_val  in  XLEN  committed value.
- commit_robid  in  ROB_ADDR  committing tag.
- ckpt_save  in  1  snapshot the map into slot ckpt_id.
- ckpt_id  in  CW  save slot.
- ckpt_restore  in  1  mispredict; restore the map from slot restore_id.
- restore_id  in  CW  restore slot.
- rf_clear  in  1  full flush of all rename state.

Behaviour:
- Reset (rst_in=1 at a clock edge): all data, busy and rely entries cleared, including every checkpoint slot.
- Reset outputs: rd_val=0, rd_has_rely=0, rd_rely=0 for every port.
- Read (combinational, zero latency): rd_val[k]=data[rd_id[k]].
- Same-cycle issue bypass: when issue_valid && issue_rd!=0 && issue_rd==rd_id[k], then rd_has_rely[k]=1 and rd_rely[k]=issue_robid.
- Otherwise rd_has_rely[k]=busy[rd_id[k]] and rd_rely[k]=rely[rd_id[k]].
- Index 0 always reads val 0, has_rely 0, rely 0.
- Priority per edge when rdy_in=1: rf_clear > ckpt_restore > normal update.
- rf_clear: busy/rely cleared in the live map and in all slots; data is kept; all other inputs are ignored.
- ckpt_restore:
  - Live busy/rely is loaded from slot restore_id.
  - A concurrent commit still writes data.
  - The commit also clears any restored entry whose rely==commit_robid.
  - Issue and save are ignored that cycle.
- Normal update, issue: issue_valid && issue_rd!=0 sets busy=1 and rely=issue_robid.
- Normal update, commit:
  - commit_valid && commit_rd!=0 writes data[commit_rd].
  - If rely[commit_rd]==commit_robid and issue_rd!=commit_rd (or no issue this cycle), busy and rely are cleared.
  - A same-cycle issue to the same register wins.
- Normal update, checkpoint scrub: each commit also clears busy/rely in every slot whose entry for commit_rd holds commit_robid. A later restore therefore never resurrects a retired producer.
- Normal update, save: ckpt_save writes the post-update map (this cycle's issue and commit applied) into slot ckpt_id, overwriting it. Slot allocation and freeing are the ROB's job.
- Saving and restoring the same slot in one cycle: restore wins, no save.
- rdy_in=0: state holds; reads remain combinational.

Optional Feature:
- Macro RF_COMMIT_BYPASS_EN.
- Defined: a read of a register with a valid commit this cycle and a matching tag (commit_rd==rd_id[k]!=0 and rely==commit_robid, no same-cycle issue bypass) returns rd_val=commit_val and rd_has_rely=0.
- Undefined: reads show pre-commit state; the consumer picks the value up from the CDB.

Test Plan:
- Reset, then read x5 on all ports -> val 0, has_rely 0, rely 0.
- Issue x5 tag 3 while port0 reads x5 -> same cycle has_rely=1, rely=3; next cycle same from the map.
- Commit x5 tag 3 val 0xDEAD with a simultaneous issue x5 tag 7 -> data=0xDEAD, busy=1, rely=7. Commit x5 tag 2 when rely=7 -> data written, busy stays.
- Issue x1 tag 1, save slot 2, issue x1 tag 4 and x2 tag 5, restore slot 2 -> x1 rely=1 busy; x2 not busy.
- Save slot 0 with x3 busy tag 6, commit x3 tag 6, restore slot 0 -> x3 not busy, data holds the committed value.
- rf_clear with several registers busy -> all has_rely=0 and data kept; a later restore from any slot shows nothing busy.
